// File: rtl/logic_analyzer_if.sv
// Pin-side bundle of the logic analyzer: probe inputs, UART line and bring-up
// debug taps.
//   dataIn           : 3-bit asynchronous probe inputs
//   TxD              : UART 8N1 transmit line, idle high
//   pll_output_debug : copy of the system clock
//   clk_div16_debug  : baud counter bit 3 (clock / 16 square wave)
//   state_debug      : one-hot FSM state
// master = board / host side, slave = analyzer.
interface logic_analyzer_if;
  logic [2:0] dataIn;
  logic       TxD;
  logic       pll_output_debug;
  logic       clk_div16_debug;
  logic [4:0] state_debug;

  modport master (
    output dataIn,
    input  TxD,
    input  pll_output_debug,
    input  clk_div16_debug,
    input  state_debug
  );

  modport slave (
    input  dataIn,
    output TxD,
    output pll_output_debug,
    output clk_div16_debug,
    output state_debug
  );
endinterface

// File: rtl/logic_analyzer.sv
// 3-channel logic analyzer. Arms on the synchronized input value, captures
// DEPTH consecutive samples on the first change, then streams them out as
// DEPTH UART 8N1 frames {index[3:0], 0, sample[2:0]} and re-arms.
// Ports:
//   inclk0_10MHz : system clock, rising edge
//   rst          : asynchronous active-high reset
//   bus          : probe inputs, TxD and debug taps (logic_analyzer_if.slave)
module logic_analyzer #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned BAUD_DIV = 16
) (
  input logic             inclk0_10MHz,
  input logic             rst,
  logic_analyzer_if.slave bus
);

  localparam int unsigned IDX_W = 4;
  localparam logic [IDX_W-1:0] DEPTH_LAST = IDX_W'(DEPTH - 1);
  localparam logic [3:0] BAUD_LAST = 4'(BAUD_DIV - 1);
  localparam logic [3:0] POS_LAST_DATA = 4'd8;
  localparam logic [3:0] POS_STOP = 4'd9;

  typedef enum logic [4:0] {
    IDLE     = 5'b00001,
    ARMED    = 5'b00010,
    CAPTURE  = 5'b00100,
    SEND     = 5'b01000,
    STOPWAIT = 5'b10000
  } state_t;

  logic clk;
  assign clk = inclk0_10MHz;

  state_t           state, state_n;
  logic [2:0]       sync_q, s;
  logic [2:0]       ref_val, ref_n;
  logic [3:0]       baud_cnt;
  logic             tick;
  logic [IDX_W-1:0] idx, idx_n;
  logic [IDX_W-1:0] byte_idx, byte_n;
  logic [3:0]       bit_pos, bit_n;   // 0 = start, 1..8 = data, 9 = stop
  logic             tx_busy, busy_n;
  logic             txd, txd_n;
  logic             wr_en;
  logic [IDX_W-1:0] wr_addr;
  logic [2:0]       buffer [DEPTH];
  logic [7:0]       tx_byte;

  assign tick    = (baud_cnt == BAUD_LAST);
  assign tx_byte = {byte_idx, 1'b0, buffer[byte_idx]};

  // Two-flop synchronizer for the asynchronous probes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      s      <= '0;
    end else begin
      sync_q <= bus.dataIn;
      s      <= sync_q;
    end
  end

  // Free-running baud counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       baud_cnt <= '0;
    else if (tick) baud_cnt <= '0;
    else           baud_cnt <= baud_cnt + 4'd1;
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state and datapath control
  always_comb begin
    state_n = state;
    ref_n   = ref_val;
    idx_n   = idx;
    byte_n  = byte_idx;
    bit_n   = bit_pos;
    busy_n  = tx_busy;
    txd_n   = txd;
    wr_en   = 1'b0;
    wr_addr = idx;
    case (state)
      IDLE: begin
        ref_n   = s;
        state_n = ARMED;
      end
      ARMED: begin
        if (s != ref_val) begin
          wr_en   = 1'b1;
          wr_addr = '0;
          idx_n   = IDX_W'(1);
          state_n = CAPTURE;
        end
      end
      CAPTURE: begin
        wr_en = 1'b1;
        idx_n = idx + IDX_W'(1);
        if (idx == DEPTH_LAST) begin
          byte_n  = '0;
          busy_n  = 1'b0;
          state_n = SEND;
        end
      end
      SEND: begin
        // Every line transition happens on a baud tick; frames run back to back
        if (tick) begin
          if (!tx_busy) begin
            busy_n = 1'b1;
            bit_n  = '0;
            txd_n  = 1'b0;
          end else if (bit_pos != POS_STOP) begin
            bit_n = bit_pos + 4'd1;
            txd_n = (bit_pos == POS_LAST_DATA) ? 1'b1 : tx_byte[bit_pos[2:0]];
          end else if (byte_idx == DEPTH_LAST) begin
            busy_n  = 1'b0;
            txd_n   = 1'b1;
            state_n = STOPWAIT;
          end else begin
            byte_n = byte_idx + IDX_W'(1);
            bit_n  = '0;
            txd_n  = 1'b0;
          end
        end
      end
      STOPWAIT: state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  // Datapath registers and sample buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_val  <= '0;
      idx      <= '0;
      byte_idx <= '0;
      bit_pos  <= '0;
      tx_busy  <= 1'b0;
      txd      <= 1'b1;
      for (int unsigned i = 0; i < DEPTH; i++) buffer[i] <= '0;
    end else begin
      ref_val  <= ref_n;
      idx      <= idx_n;
      byte_idx <= byte_n;
      bit_pos  <= bit_n;
      tx_busy  <= busy_n;
      txd      <= txd_n;
      if (wr_en) buffer[wr_addr] <= s;
    end
  end

  assign bus.TxD              = txd;
  assign bus.state_debug      = state;
  assign bus.clk_div16_debug  = baud_cnt[3];
  assign bus.pll_output_debug = inclk0_10MHz;

endmodule

// File: tb/tb_logic_analyzer.sv
// Bench for logic_analyzer: expected UART bytes are queued when stimulus is
// applied and popped as a bench-side UART receiver decodes TxD.
module tb_logic_analyzer;

  localparam logic [4:0] ST_IDLE     = 5'b00001;
  localparam logic [4:0] ST_ARMED    = 5'b00010;
  localparam logic [4:0] ST_SEND     = 5'b01000;
  localparam logic [4:0] ST_STOPWAIT = 5'b10000;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  int   cyc;
  int   last_start;
  logic [7:0] exp_q [$];
  int   start_q [$];

  logic_analyzer_if bus();

  logic_analyzer #(.DEPTH(16), .BAUD_DIV(16)) dut (
    .inclk0_10MHz(clk),
    .rst         (rst),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Receive n frames, compare each against the scoreboard and check spacing
  task automatic rx_frames(input int n, input int budget);
    int waited;
    int t0;
    logic [7:0] got;
    logic [7:0] exp_b;
    logic start_ok;
    logic stop_ok;
    for (int f = 0; f < n; f++) begin
      waited = 0;
      while (bus.TxD !== 1'b0 && waited < budget) begin
        @(negedge clk);
        waited++;
      end
      n_checks++;
      if (waited >= budget) begin
        $display("FAIL rx_start frame %0d: TxD=%b, start bit required within %0d cycles", f, bus.TxD, budget);
        return;
      end
      n_pass++;
      t0 = cyc;
      start_q.push_back(t0);
      repeat (7) @(negedge clk);
      start_ok = (bus.TxD === 1'b0);
      for (int b = 0; b < 8; b++) begin
        repeat (16) @(negedge clk);
        got[b] = bus.TxD;
      end
      repeat (16) @(negedge clk);
      stop_ok = (bus.TxD === 1'b1);
      n_checks++;
      if (!start_ok || !stop_ok)
        $display("FAIL rx_framing frame %0d: start_ok=%b stop_ok=%b, required 1 1", f, start_ok, stop_ok);
      else n_pass++;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL rx_data frame %0d: got 0x%02h, no byte expected", f, got);
      end else begin
        exp_b = exp_q.pop_front();
        if (got !== exp_b)
          $display("FAIL rx_data frame %0d: got 0x%02h, required 0x%02h", f, got, exp_b);
        else n_pass++;
      end
      if (last_start >= 0) begin
        n_checks++;
        if (t0 - last_start !== 160)
          $display("FAIL frame_spacing frame %0d: %0d cycles, required 160", f, t0 - last_start);
        else n_pass++;
      end
      last_start = t0;
    end
  endtask

  // Six-step sequence, 150 time units per step, phased against the clock
  task automatic drive_steps();
    @(posedge clk);
    #25  bus.dataIn = 3'b001;
    #150 bus.dataIn = 3'b010;
    #150 bus.dataIn = 3'b011;
    #150 bus.dataIn = 3'b100;
    #150 bus.dataIn = 3'b101;
    #150 bus.dataIn = 3'b110;
  endtask

  task automatic test_reset();
    int r1;
    int r2;
    logic prev;
    rst = 1'b1;
    bus.dataIn = 3'b000;
    #500;
    @(negedge clk);
    n_checks++;
    if (bus.TxD !== 1'b1) $display("FAIL reset_txd: got %b, required 1", bus.TxD);
    else n_pass++;
    n_checks++;
    if (bus.state_debug !== ST_IDLE) $display("FAIL reset_state: got %b, required %b", bus.state_debug, ST_IDLE);
    else n_pass++;
    n_checks++;
    if (bus.clk_div16_debug !== 1'b0) $display("FAIL reset_clkdiv: got %b, required 0", bus.clk_div16_debug);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.state_debug !== ST_ARMED) $display("FAIL armed_after_reset: got %b, required %b", bus.state_debug, ST_ARMED);
    else n_pass++;
    r1 = -1;
    r2 = -1;
    prev = bus.clk_div16_debug;
    for (int i = 0; i < 100 && r2 < 0; i++) begin
      @(negedge clk);
      if (!prev && bus.clk_div16_debug === 1'b1) begin
        if (r1 < 0) r1 = cyc;
        else r2 = cyc;
      end
      prev = bus.clk_div16_debug;
    end
    n_checks++;
    if (r1 < 0 || r2 < 0 || r2 - r1 !== 16)
      $display("FAIL clkdiv_period: got %0d cycles, required 16", r2 - r1);
    else n_pass++;
  endtask

  task automatic test_debug_clock();
    @(negedge clk);
    n_checks++;
    if (bus.pll_output_debug !== 1'b0) $display("FAIL pll_low: got %b, required 0", bus.pll_output_debug);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.pll_output_debug !== 1'b1) $display("FAIL pll_high: got %b, required 1", bus.pll_output_debug);
    else n_pass++;
  endtask

  task automatic test_no_trigger();
    int bad;
    bad = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bus.TxD !== 1'b1 || bus.state_debug !== ST_ARMED) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL no_trigger: %0d cycles not idle/ARMED, required 0", bad);
    else n_pass++;
  endtask

  task automatic test_single_step();
    int send_c;
    int k;
    int bad;
    send_c = -1;
    last_start = -1;
    start_q.delete();
    @(negedge clk);
    bus.dataIn = 3'b101;
    for (int i = 0; i < 16; i++) exp_q.push_back({4'(i), 1'b0, 3'b101});
    for (int i = 0; i < 50 && send_c < 0; i++) begin
      @(negedge clk);
      if (bus.state_debug === ST_SEND) send_c = cyc;
      else if (bus.TxD !== 1'b1) bad = 1;
    end
    n_checks++;
    if (send_c < 0) $display("FAIL enter_send: state %b, required %b within 50 cycles", bus.state_debug, ST_SEND);
    else n_pass++;
    rx_frames(16, 40);
    n_checks++;
    if (start_q.size() == 0 || start_q[0] - send_c < 1 || start_q[0] - send_c > 16)
      $display("FAIL first_start_delay: got %0d cycles, required 1..16", (start_q.size() == 0) ? -1 : start_q[0] - send_c);
    else n_pass++;
    k = 0;
    while (bus.state_debug === ST_SEND && k < 30) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (bus.state_debug !== ST_STOPWAIT) $display("FAIL stopwait: got %b, required %b", bus.state_debug, ST_STOPWAIT);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus.state_debug !== ST_IDLE) $display("FAIL back_to_idle: got %b, required %b", bus.state_debug, ST_IDLE);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus.state_debug !== ST_ARMED) $display("FAIL rearm: got %b, required %b", bus.state_debug, ST_ARMED);
    else n_pass++;
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (bus.TxD !== 1'b1 || bus.state_debug !== ST_ARMED) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL ref_relatched: %0d cycles not idle/ARMED, required 0", bad);
    else n_pass++;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL single_leftover: %0d bytes unsent, required 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_stepped_and_change_during_send();
    logic [2:0] seq [7];
    logic [2:0] v;
    int k;
    int bad;
    seq = '{3'b001, 3'b010, 3'b010, 3'b011, 3'b100, 3'b100, 3'b101};
    bus.dataIn = 3'b000;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.state_debug !== ST_ARMED) $display("FAIL stepped_armed: got %b, required %b", bus.state_debug, ST_ARMED);
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      v = (i < 7) ? seq[i] : 3'b110;
      exp_q.push_back({4'(i), 1'b0, v});
    end
    last_start = -1;
    start_q.delete();
    drive_steps();
    fork
      rx_frames(16, 100);
      begin
        repeat (1000) @(negedge clk);
        drive_steps();
      end
    join
    k = 0;
    while (bus.state_debug !== ST_ARMED && k < 30) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (bus.state_debug !== ST_ARMED) $display("FAIL stepped_rearm: got %b, required %b", bus.state_debug, ST_ARMED);
    else n_pass++;
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (bus.TxD !== 1'b1 || bus.state_debug !== ST_ARMED) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL no_extra_capture: %0d cycles not idle/ARMED, required 0", bad);
    else n_pass++;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL stepped_leftover: %0d bytes unsent, required 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset_during_send();
    int k;
    int bad;
    @(negedge clk);
    bus.dataIn = 3'b000;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h10);
    last_start = -1;
    start_q.delete();
    rx_frames(2, 100);
    k = 0;
    while (bus.TxD !== 1'b0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (bus.TxD !== 1'b0) $display("FAIL third_start: TxD=%b, required 0", bus.TxD);
    else n_pass++;
    repeat (50) @(negedge clk);
    #20 rst = 1'b1;
    #5;
    n_checks++;
    if (bus.TxD !== 1'b1) $display("FAIL async_reset_txd: got %b, required 1", bus.TxD);
    else n_pass++;
    n_checks++;
    if (bus.state_debug !== ST_IDLE) $display("FAIL async_reset_state: got %b, required %b", bus.state_debug, ST_IDLE);
    else n_pass++;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bus.TxD !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL quiet_after_reset: %0d cycles TxD low, required 0", bad);
    else n_pass++;
    n_checks++;
    if (bus.state_debug !== ST_ARMED) $display("FAIL armed_after_abort: got %b, required %b", bus.state_debug, ST_ARMED);
    else n_pass++;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL abort_leftover: %0d bytes unsent, required 0", exp_q.size());
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    last_start = -1;
    rst = 1'b1;
    bus.dataIn = 3'b000;
    test_reset();
    test_debug_clock();
    test_no_trigger();
    test_single_step();
    test_stepped_and_change_during_send();
    test_reset_during_send();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #50000000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
